// File: rtl/bus_master_arbiter.sv
// Two-master round-robin arbiter for the 8-bit register bus.
// Sequences one BUS_WR/BUS_RD strobe per transaction and returns an ACK.
//
// Ports:
//   BUS_CLK, BUS_RST       clock, synchronous active-high reset
//   M0_*/M1_*              master request, direction, address, write data,
//                          one-cycle ACK and held read data
//   BUS_WR, BUS_RD         single-cycle bus strobes
//   BUS_ADD, BUS_DATA_IN   address and write data, zero while idle
//   BUS_DATA_OUT           read data returned by the peripherals
//   BUSY                   high while a transaction is in flight
module bus_master_arbiter #(
    parameter int ABUSWIDTH    = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 M0_REQ,
    input  logic                 M0_WE,
    input  logic [ABUSWIDTH-1:0] M0_ADD,
    input  logic [7:0]           M0_WD,
    output logic                 M0_ACK,
    output logic [7:0]           M0_RD,
    input  logic                 M1_REQ,
    input  logic                 M1_WE,
    input  logic [ABUSWIDTH-1:0] M1_ADD,
    input  logic [7:0]           M1_WD,
    output logic                 M1_ACK,
    output logic [7:0]           M1_RD,
    output logic                 BUS_WR,
    output logic                 BUS_RD,
    output logic [ABUSWIDTH-1:0] BUS_ADD,
    output logic [7:0]           BUS_DATA_IN,
    input  logic [7:0]           BUS_DATA_OUT,
    output logic                 BUSY
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STRB = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic                 last_q, last_d;
    logic                 gnt_q, gnt_d;
    logic                 we_q, we_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ABUSWIDTH-1:0] add_q, add_d;
    logic [7:0]           din_q, din_d;
    logic [7:0]           rd0_q, rd0_d;
    logic [7:0]           rd1_q, rd1_d;
    logic                 wr_q, wr_d;
    logic                 rs_q, rs_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 busy_q, busy_d;
    logic                 sel;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        add_d   = add_q;
        din_d   = din_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        wr_d    = 1'b0;
        rs_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        sel     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (M0_REQ || M1_REQ) begin
                    // Contention goes to the master that did not win last.
                    sel     = (M0_REQ && M1_REQ) ? ~last_q : M1_REQ;
                    gnt_d   = sel;
                    last_d  = sel;
                    we_d    = sel ? M1_WE  : M0_WE;
                    add_d   = sel ? M1_ADD : M0_ADD;
                    din_d   = sel ? M1_WD  : M0_WD;
                    wr_d    = we_d;
                    rs_d    = ~we_d;
                    state_d = S_STRB;
                end
            end
            S_STRB: begin
                if (we_q) begin
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d   = 4'(READ_LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (gnt_q) rd1_d = BUS_DATA_OUT;
                    else       rd0_d = BUS_DATA_OUT;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                add_d   = '0;
                din_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            add_q   <= '0;
            din_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            wr_q    <= 1'b0;
            rs_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            add_q   <= add_d;
            din_q   <= din_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            wr_q    <= wr_d;
            rs_q    <= rs_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign M0_ACK      = ack0_q;
    assign M1_ACK      = ack1_q;
    assign M0_RD       = rd0_q;
    assign M1_RD       = rd1_q;
    assign BUS_WR      = wr_q;
    assign BUS_RD      = rs_q;
    assign BUS_ADD     = add_q;
    assign BUS_DATA_IN = din_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Scoreboard bench for bus_master_arbiter.
// Main instance uses READ_LATENCY=1, a second instance READ_LATENCY=4.
module tb_bus_master_arbiter;

    typedef struct {
        bit          m;
        bit          we;
        logic [31:0] a;
        logic [7:0]  d;
    } bus_t;

    typedef struct {
        bit         m;
        bit         we;
        logic [7:0] rd;
    } ack_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        prst;
    logic        req [2];
    logic        we  [2];
    logic [31:0] add [2];
    logic [7:0]  wd  [2];
    logic        ack0, ack1;
    logic [7:0]  rd0, rd1;
    logic        bwr, brd, busy;
    logic [31:0] badd;
    logic [7:0]  bdin, bdout;

    logic        r4_req;
    logic [31:0] r4_add;
    logic        a4_ack0, a4_ack1;
    logic [7:0]  a4_rd0, a4_rd1;
    logic        b4_wr, b4_rd, b4_busy;
    logic [31:0] b4_add;
    logic [7:0]  b4_din, b4_dout;

    bus_master_arbiter #(.ABUSWIDTH(32), .READ_LATENCY(1)) dut (
        .BUS_CLK(clk), .BUS_RST(rst),
        .M0_REQ(req[0]), .M0_WE(we[0]), .M0_ADD(add[0]), .M0_WD(wd[0]),
        .M0_ACK(ack0), .M0_RD(rd0),
        .M1_REQ(req[1]), .M1_WE(we[1]), .M1_ADD(add[1]), .M1_WD(wd[1]),
        .M1_ACK(ack1), .M1_RD(rd1),
        .BUS_WR(bwr), .BUS_RD(brd), .BUS_ADD(badd),
        .BUS_DATA_IN(bdin), .BUS_DATA_OUT(bdout), .BUSY(busy)
    );

    bus_master_arbiter #(.ABUSWIDTH(32), .READ_LATENCY(4)) dut4 (
        .BUS_CLK(clk), .BUS_RST(rst),
        .M0_REQ(r4_req), .M0_WE(1'b0), .M0_ADD(r4_add), .M0_WD(8'h00),
        .M0_ACK(a4_ack0), .M0_RD(a4_rd0),
        .M1_REQ(1'b0), .M1_WE(1'b0), .M1_ADD(32'h0), .M1_WD(8'h00),
        .M1_ACK(a4_ack1), .M1_RD(a4_rd1),
        .BUS_WR(b4_wr), .BUS_RD(b4_rd), .BUS_ADD(b4_add),
        .BUS_DATA_IN(b4_din), .BUS_DATA_OUT(b4_dout), .BUSY(b4_busy)
    );

    // Peripheral for the RL=1 instance: registered read, data only
    // present in the one cycle after BUS_RD.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (prst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h20] <= 8'h3C;
            bdout <= 8'h00;
        end else begin
            if (bwr) mem[badd[7:0]] <= bdin;
            bdout <= brd ? mem[badd[7:0]] : 8'h00;
        end
    end

    // Peripheral for the RL=4 instance: 0x7E exactly 4 cycles after BUS_RD.
    logic [3:0] p4;
    always @(posedge clk) begin
        if (prst) p4 <= 4'h0;
        else      p4 <= {p4[2:0], b4_rd};
    end
    assign b4_dout = p4[3] ? 8'h7E : 8'h00;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s", nm, why);
    endtask

    bus_t       bq [$];
    ack_t       aq [$];
    logic [7:0] lastrd [2];

    task automatic exp_tx(input bit m, input bit w, input logic [31:0] a,
                          input logic [7:0] d, input logic [7:0] r);
        bus_t b;
        ack_t k;
        b.m = m; b.we = w; b.a = a; b.d = d;
        k.m = m; k.we = w; k.rd = r;
        bq.push_back(b);
        aq.push_back(k);
    endtask

    // Monitor: pops expectations whenever the DUT shows a strobe or ACK.
    bit   mon_on = 1'b0;
    logic prev_busy = 1'b0;
    int   scyc = 0;
    bus_t mb;
    ack_t ma;
    always @(negedge clk) begin
        if (mon_on) begin
            if (!busy) check("idle_bus_zero", 64'({badd, bdin}), 64'h0);
            if (bwr || brd) begin
                check("strobe_excl", 64'(bwr & brd), 64'h0);
                check("strobe_gap", 64'(prev_busy), 64'h0);
                if (bq.size() == 0) begin
                    fail("spurious_strobe", "got strobe, want none");
                end else begin
                    mb = bq.pop_front();
                    check("strobe_dir", 64'(bwr), 64'(mb.we));
                    check("strobe_add", 64'(badd), 64'(mb.a));
                    if (mb.we) check("strobe_wd", 64'(bdin), 64'(mb.d));
                    scyc = cyc;
                end
            end
            if (ack0 || ack1) begin
                check("ack_excl", 64'(ack0 & ack1), 64'h0);
                if (aq.size() == 0) begin
                    fail("spurious_ack", "got ACK, want none");
                end else begin
                    ma = aq.pop_front();
                    check("ack_master", 64'(ack1), 64'(ma.m));
                    if (!ma.we) lastrd[ma.m] = ma.rd;
                    check("ack_rd0", 64'(rd0), 64'(lastrd[0]));
                    check("ack_rd1", 64'(rd1), 64'(lastrd[1]));
                    check("ack_latency", 64'(cyc - scyc),
                          ma.we ? 64'd1 : 64'd2);
                end
            end
            prev_busy = busy;
        end
    end

    // Caller must be #1 after a posedge. REQ is dropped the cycle after ACK.
    task automatic run(input int m, input bit w, input logic [31:0] a,
                       input logic [7:0] d, input int hold);
        int n;
        bit got;
        req[m] = 1'b1; we[m] = w; add[m] = a; wd[m] = d;
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = (m == 1) ? ack1 : ack0;
        end
        if (!got) fail("ack_timeout", "got no ACK in 60 cycles, want ACK");
        repeat (hold + 1) @(posedge clk);
        #1;
        req[m] = 1'b0;
    endtask

    initial begin
        int first_rd;
        int ack_c;
        int strobes;
        int acks4;
        int n;
        rst = 1'b1; prst = 1'b1;
        r4_req = 1'b0; r4_add = '0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; add[i] = '0; wd[i] = '0;
            lastrd[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; prst = 1'b0;
        @(negedge clk);
        check("rst_out", 64'({bwr, brd, ack0, ack1, busy}), 64'h0);
        check("rst_bus", 64'({badd, bdin}), 64'h0);
        check("rst_rd", 64'({rd0, rd1}), 64'h0);
        check("rst_dut4", 64'({b4_wr, b4_rd, a4_ack0, b4_busy, a4_rd0}),
              64'h0);
        mon_on = 1'b1;

        // M0 write 0x1000 <- 0xA5
        exp_tx(0, 1, 32'h1000, 8'hA5, 8'h00);
        @(posedge clk); #1;
        run(0, 1, 32'h1000, 8'hA5, 0);

        // M1 read 0x20 -> 0x3C
        exp_tx(1, 0, 32'h20, 8'h00, 8'h3C);
        @(posedge clk); #1;
        run(1, 0, 32'h20, 8'h00, 0);

        // Simultaneous requests, two back-to-back each: M0,M1,M0,M1
        exp_tx(0, 1, 32'h30, 8'h11, 8'h00);
        exp_tx(1, 0, 32'h1000, 8'h00, 8'hA5);
        exp_tx(0, 0, 32'h30, 8'h00, 8'h11);
        exp_tx(1, 1, 32'h31, 8'h22, 8'h00);
        @(posedge clk); #1;
        fork
            begin
                run(0, 1, 32'h30, 8'h11, 0);
                run(0, 0, 32'h30, 8'h00, 0);
            end
            begin
                run(1, 0, 32'h1000, 8'h00, 0);
                run(1, 1, 32'h31, 8'h22, 0);
            end
        join

        // RL=4 instance: data captured 4 cycles after BUS_RD, ACK next
        first_rd = -1; ack_c = -1; strobes = 0; acks4 = 0;
        @(posedge clk); #1;
        r4_req = 1'b1; r4_add = 32'h44;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b4_rd && first_rd < 0) first_rd = i;
            if (b4_rd || b4_wr) strobes++;
            if (a4_ack0 || a4_ack1) acks4++;
            if (a4_ack0 && ack_c < 0) begin
                ack_c = i;
                check("rl4_rd", 64'(a4_rd0), 64'h7E);
                @(posedge clk); #1;
                r4_req = 1'b0;
            end
        end
        check("rl4_strobes", 64'(strobes), 64'd1);
        check("rl4_acks", 64'(acks4), 64'd1);
        check("rl4_latency", 64'(ack_c - first_rd), 64'd5);
        check("rl4_idle", 64'({b4_busy, b4_add, a4_ack1}), 64'h0);

        // Reset during the WAIT cycle of an M0 read
        bq.push_back('{1'b0, 1'b0, 32'h30, 8'h00});
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; add[0] = 32'h30;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!brd && n < 20);
        if (!brd) fail("rst_wait_timeout", "got no BUS_RD, want BUS_RD");
        @(posedge clk); #1;
        rst = 1'b1; req[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out", 64'({bwr, brd, ack0, ack1, busy}), 64'h0);
        check("abort_bus", 64'({badd, bdin}), 64'h0);
        check("abort_rd", 64'({rd0, rd1}), 64'h0);
        lastrd[0] = 8'h00;
        lastrd[1] = 8'h00;
        exp_tx(0, 0, 32'h30, 8'h00, 8'h11);
        @(posedge clk); #1;
        run(0, 0, 32'h30, 8'h00, 0);

        // M0 holds REQ 3 cycles past ACK: exactly one more transaction
        exp_tx(0, 1, 32'h50, 8'h66, 8'h00);
        exp_tx(0, 1, 32'h50, 8'h66, 8'h00);
        @(posedge clk); #1;
        run(0, 1, 32'h50, 8'h66, 3);

        repeat (8) @(posedge clk);
        @(negedge clk);
        check("bus_q_empty", 64'(bq.size()), 64'd0);
        check("ack_q_empty", 64'(aq.size()), 64'd0);
        check("final_idle", 64'({busy, bwr, brd}), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
